// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage RV32 pipeline.
//
// Takes the EX/MEM pipeline-register fields and issues loads and stores to
// the data-memory port through a req/ack handshake. While an access is
// outstanding, mem_stall holds the EX/MEM register and everything upstream.
// Load data is aligned and sign- or zero-extended. The write-back result is
// registered into the MEM/WB pipeline register.
//
// Parameters
//   TIMEOUT      maximum number of WAIT cycles before the access is
//                abandoned (1..255)
//
// Ports
//   clk, rst     clock (rising edge); synchronous active-high reset
//   datatype     funct3 access size: 0=B 1=H 2=W 4=BU 5=HU, others = W
//   alu_out      effective address, or the ALU result
//   dm_data      store data (rs2)
//   pc2reg       PC+4 for JAL/JALR
//   rd_addr      destination register
//   reg_wr       register write enable from decode
//   rd_src       1 selects pc2reg as the result
//   dm2reg       1 selects load data as the result
//   dm_rd/dm_wr  load / store request (dm_rd wins if both are set)
//   dm_req       memory request
//   dm_addr      word-aligned address
//   dm_we        byte write enables (zero for reads)
//   dm_wdata     lane-replicated store data
//   dm_ack       access complete; dm_rdata is valid in the same cycle
//   dm_rdata     read word
//   mem_stall    hold the EX/MEM register and everything upstream
//   wb_reg_wr    MEM/WB register write enable
//   wb_rd_addr   MEM/WB destination register
//   wb_data      MEM/WB write-back value
//   mem_misalign one-cycle pulse after a misaligned access
//   mem_bus_err  one-cycle pulse after an access timeout
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  datatype,
  input  logic [31:0] alu_out,
  input  logic [31:0] dm_data,
  input  logic [31:0] pc2reg,
  input  logic [4:0]  rd_addr,
  input  logic        reg_wr,
  input  logic        rd_src,
  input  logic        dm2reg,
  input  logic        dm_rd,
  input  logic        dm_wr,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        wb_reg_wr,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        mem_misalign,
  output logic        mem_bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  state_t      state, state_n;
  logic [7:0]  wait_cnt, wait_cnt_n;

  size_t       size;
  logic        load_unsigned;
  logic        access;
  logic        is_store;
  logic        misaligned;
  logic        aligned_access;
  logic [3:0]  store_we;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] result;

  logic        complete;
  logic        timeout;

  // -------------------------------------------------------------------------
  // Access decode
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    size = SZ_W;
    unique case (datatype)
      3'd0, 3'd4: size = SZ_B;
      3'd1, 3'd5: size = SZ_H;
      default:    size = SZ_W;
    endcase
  end

  // Only meaningful for B/H; for W the word passes through unchanged.
  assign load_unsigned = datatype[2];

  assign access   = dm_rd | dm_wr;
  // A load wins when both request bits are set.
  assign is_store = dm_wr & ~dm_rd;

  // Only memory accesses can be misaligned; an ALU result with low address
  // bits set is just a value.
  assign misaligned = access &
                      (((size == SZ_H) & alu_out[0]) |
                       ((size == SZ_W) & (alu_out[1:0] != 2'b00)));

  assign aligned_access = access & ~misaligned;

  assign dm_addr = {alu_out[31:2], 2'b00};

  // -------------------------------------------------------------------------
  // Store lane placement
  // -------------------------------------------------------------------------
  always_comb begin
    store_we = 4'b1111;
    dm_wdata = dm_data;
    unique case (size)
      SZ_B: begin
        store_we = 4'b0001 << alu_out[1:0];
        dm_wdata = {4{dm_data[7:0]}};
      end
      SZ_H: begin
        store_we = alu_out[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{dm_data[15:0]}};
      end
      default: begin
        store_we = 4'b1111;
        dm_wdata = dm_data;
      end
    endcase
  end

  // Byte enables are only driven while a store request is actually on the
  // bus, so misaligned stores and idle cycles never present a write.
  assign dm_we = (dm_req & is_store) ? store_we : 4'b0000;

  // -------------------------------------------------------------------------
  // Load extraction and result select
  // -------------------------------------------------------------------------
  assign lane_byte = dm_rdata[{alu_out[1:0], 3'b000} +: 8];
  assign lane_half = alu_out[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    load_ext = dm_rdata;
    unique case (size)
      SZ_B:    load_ext = load_unsigned ? {24'h0, lane_byte}
                                        : {{24{lane_byte[7]}}, lane_byte};
      SZ_H:    load_ext = load_unsigned ? {16'h0, lane_half}
                                        : {{16{lane_half[15]}}, lane_half};
      default: load_ext = dm_rdata;
    endcase
  end

  assign result = dm2reg ? load_ext : (rd_src ? pc2reg : alu_out);

  // -------------------------------------------------------------------------
  // Handshake FSM: next state and outputs
  // -------------------------------------------------------------------------
  // complete: MEM/WB captures the result this cycle.
  // timeout : the outstanding access is abandoned this cycle.
  // Any cycle with neither loads a bubble into MEM/WB.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    dm_req     = 1'b0;
    mem_stall  = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (aligned_access) begin
          dm_req = 1'b1;
          if (dm_ack) begin
            complete = 1'b1;
          end else begin
            mem_stall  = 1'b1;
            wait_cnt_n = 8'd1;
            state_n    = ST_WAIT;
          end
        end else begin
          // Non-memory instructions complete at once; a stray dm_ack has no
          // effect. A misaligned access never completes, so its write-back
          // is suppressed.
          complete = ~misaligned;
        end
      end

      ST_WAIT: begin
        // The EX/MEM fields are frozen by the stall, so address, enables and
        // write data stay stable without extra holding registers.
        dm_req = 1'b1;
        if (dm_ack) begin
          complete   = 1'b1;
          wait_cnt_n = 8'd0;
          state_n    = ST_IDLE;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          timeout    = 1'b1;
          wait_cnt_n = 8'd0;
          state_n    = ST_IDLE;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_n    = ST_IDLE;
        wait_cnt_n = 8'd0;
      end
    endcase

    // Hold the bus and the pipeline quiet for the whole reset cycle.
    if (rst) begin
      dm_req    = 1'b0;
      mem_stall = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State, counter and MEM/WB register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= 8'd0;
      wb_reg_wr    <= 1'b0;
      wb_rd_addr   <= 5'd0;
      wb_data      <= 32'h0;
      mem_misalign <= 1'b0;
      mem_bus_err  <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_cnt_n;
      mem_misalign <= (state == ST_IDLE) & misaligned;
      mem_bus_err  <= timeout;
      if (complete) begin
        // x0 is hard-wired zero: never request a write to it.
        wb_reg_wr  <= reg_wr & (rd_addr != 5'd0);
        wb_rd_addr <= rd_addr;
        wb_data    <= result;
      end else begin
        wb_reg_wr  <= 1'b0;
        wb_rd_addr <= 5'd0;
        wb_data    <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked in the same cycle after a settle delay, registered outputs 1 time
// unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  datatype;
  logic [31:0] alu_out;
  logic [31:0] dm_data;
  logic [31:0] pc2reg;
  logic [4:0]  rd_addr;
  logic        reg_wr;
  logic        rd_src;
  logic        dm2reg;
  logic        dm_rd;
  logic        dm_wr;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic        wb_reg_wr;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        mem_misalign;
  logic        mem_bus_err;

  int checks   = 0;
  int failures = 0;
  int stall_cycles;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .datatype     (datatype),
    .alu_out      (alu_out),
    .dm_data      (dm_data),
    .pc2reg       (pc2reg),
    .rd_addr      (rd_addr),
    .reg_wr       (reg_wr),
    .rd_src       (rd_src),
    .dm2reg       (dm2reg),
    .dm_rd        (dm_rd),
    .dm_wr        (dm_wr),
    .dm_req       (dm_req),
    .dm_addr      (dm_addr),
    .dm_we        (dm_we),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .mem_stall    (mem_stall),
    .wb_reg_wr    (wb_reg_wr),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .mem_misalign (mem_misalign),
    .mem_bus_err  (mem_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    datatype = 3'd0;
    alu_out  = 32'h0;
    dm_data  = 32'h0;
    pc2reg   = 32'h0;
    rd_addr  = 5'd0;
    reg_wr   = 1'b0;
    rd_src   = 1'b0;
    dm2reg   = 1'b0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
  endtask

  task automatic load(input logic [2:0] dt, input logic [31:0] addr,
                      input logic [4:0] rd, input logic ack,
                      input logic [31:0] rdata);
    nop();
    datatype = dt;
    alu_out  = addr;
    rd_addr  = rd;
    reg_wr   = 1'b1;
    dm2reg   = 1'b1;
    dm_rd    = 1'b1;
    dm_ack   = ack;
    dm_rdata = rdata;
  endtask

  task automatic store(input logic [2:0] dt, input logic [31:0] addr,
                       input logic [31:0] data, input logic ack);
    nop();
    datatype = dt;
    alu_out  = addr;
    dm_data  = data;
    dm_wr    = 1'b1;
    dm_ack   = ack;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    nop();
    tick();
    tick();
    check("rst_dm_req",     32'(dm_req),       0);
    check("rst_dm_we",      32'(dm_we),        0);
    check("rst_stall",      32'(mem_stall),    0);
    check("rst_wb_reg_wr",  32'(wb_reg_wr),    0);
    check("rst_wb_rd_addr", 32'(wb_rd_addr),   0);
    check("rst_wb_data",    wb_data,           0);
    check("rst_misalign",   32'(mem_misalign), 0);
    check("rst_bus_err",    32'(mem_bus_err),  0);
    rst = 1'b0;

    // ---------------- zero-wait LW ----------------
    load(3'd2, 32'h0000_0100, 5'd5, 1'b1, 32'hDEAD_BEEF);
    #1;
    check("lw_req",   32'(dm_req),    1);
    check("lw_stall", 32'(mem_stall), 0);
    check("lw_addr",  dm_addr,        32'h0000_0100);
    check("lw_we",    32'(dm_we),     0);
    tick();
    // Back-to-back: LB issues immediately after the ack cycle.
    load(3'd0, 32'h0000_0103, 5'd6, 1'b1, 32'h8000_0000);
    #1;
    check("lw_wb_reg_wr",  32'(wb_reg_wr),  1);
    check("lw_wb_rd_addr", 32'(wb_rd_addr), 5);
    check("lw_wb_data",    wb_data,         32'hDEAD_BEEF);
    check("lb_req",        32'(dm_req),     1);
    check("lb_stall",      32'(mem_stall),  0);
    tick();
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);

    load(3'd4, 32'h0000_0103, 5'd6, 1'b1, 32'h8000_0000);
    tick();
    check("lbu_wb_data", wb_data, 32'h0000_0080);

    load(3'd1, 32'h0000_0102, 5'd6, 1'b1, 32'h8001_0000);
    tick();
    check("lh_wb_data", wb_data, 32'hFFFF_8001);

    load(3'd5, 32'h0000_0102, 5'd6, 1'b1, 32'h8001_0000);
    tick();
    check("lhu_wb_data", wb_data, 32'h0000_8001);

    // ---------------- SB with three wait cycles ----------------
    store(3'd0, 32'h0000_0201, 32'h0000_00AB, 1'b0);
    #1;
    check("sb_addr",  dm_addr,        32'h0000_0200);
    check("sb_we",    32'(dm_we),     32'h2);
    check("sb_wdata", dm_wdata,       32'hABAB_ABAB);
    check("sb_req0",  32'(dm_req),    1);
    check("sb_stall0", 32'(mem_stall), 1);
    tick();
    check("sb_req1",   32'(dm_req),    1);
    check("sb_we1",    32'(dm_we),     32'h2);
    check("sb_stall1", 32'(mem_stall), 1);
    check("sb_bubble_wr", 32'(wb_reg_wr), 0);
    tick();
    check("sb_req2",   32'(dm_req),    1);
    check("sb_stall2", 32'(mem_stall), 1);
    tick();
    dm_ack = 1'b1;
    #1;
    check("sb_req3",   32'(dm_req),    1);
    check("sb_stall3", 32'(mem_stall), 0);
    tick();
    nop();
    #1;
    check("sb_wb_reg_wr", 32'(wb_reg_wr), 0);

    // ---------------- other store lanes ----------------
    store(3'd1, 32'h0000_0502, 32'h0000_BEEF, 1'b1);
    #1;
    check("sh_we",    32'(dm_we), 32'hC);
    check("sh_wdata", dm_wdata,   32'hBEEF_BEEF);
    store(3'd2, 32'h0000_0500, 32'h1234_5678, 1'b1);
    #1;
    check("sw_we",    32'(dm_we), 32'hF);
    check("sw_wdata", dm_wdata,   32'h1234_5678);
    // Both request bits set: the load wins, no byte enables.
    dm_rd = 1'b1;
    #1;
    check("rdwr_we", 32'(dm_we), 0);
    tick();

    // ---------------- misaligned LW then SH ----------------
    load(3'd2, 32'h0000_0102, 5'd7, 1'b0, 32'h0);
    #1;
    check("mis_lw_req",   32'(dm_req),    0);
    check("mis_lw_stall", 32'(mem_stall), 0);
    tick();
    check("mis_lw_pulse",  32'(mem_misalign), 1);
    check("mis_lw_reg_wr", 32'(wb_reg_wr),    0);
    store(3'd1, 32'h0000_0101, 32'h0000_1234, 1'b0);
    reg_wr  = 1'b1;
    rd_addr = 5'd8;
    #1;
    check("mis_sh_req",   32'(dm_req),    0);
    check("mis_sh_stall", 32'(mem_stall), 0);
    check("mis_sh_we",    32'(dm_we),     0);
    tick();
    check("mis_sh_pulse",  32'(mem_misalign), 1);
    check("mis_sh_reg_wr", 32'(wb_reg_wr),    0);
    nop();
    tick();
    check("mis_pulse_end", 32'(mem_misalign), 0);

    // ---------------- timeout ----------------
    load(3'd2, 32'h0000_0300, 5'd9, 1'b0, 32'h0);
    #1;
    stall_cycles = 0;
    while (mem_stall && stall_cycles < 20) begin
      stall_cycles++;
      tick();
    end
    check("to_stall_cycles", stall_cycles, 4);
    check("to_req_release",  32'(dm_req),  1);
    check("to_err_early",    32'(mem_bus_err), 0);
    tick();
    nop();
    #1;
    check("to_bus_err", 32'(mem_bus_err), 1);
    check("to_reg_wr",  32'(wb_reg_wr),   0);
    // Back in IDLE: a zero-wait load completes without stalling.
    load(3'd2, 32'h0000_0304, 5'd10, 1'b1, 32'h0BAD_F00D);
    #1;
    check("to_idle_stall", 32'(mem_stall), 0);
    tick();
    check("to_err_once",     32'(mem_bus_err), 0);
    check("to_after_rd",     32'(wb_rd_addr),  10);
    check("to_after_data",   wb_data,          32'h0BAD_F00D);

    // ---------------- reset during WAIT ----------------
    load(3'd2, 32'h0000_0400, 5'd3, 1'b0, 32'h0);
    tick();
    tick();
    check("rw_stall_before", 32'(mem_stall), 1);
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    #1;
    check("rw_req",        32'(dm_req),     0);
    check("rw_stall",      32'(mem_stall),  0);
    check("rw_wb_reg_wr",  32'(wb_reg_wr),  0);
    check("rw_wb_rd_addr", 32'(wb_rd_addr), 0);
    check("rw_wb_data",    wb_data,         0);

    // ---------------- JAL and rd=0 ----------------
    nop();
    rd_src  = 1'b1;
    pc2reg  = 32'h0000_0044;
    alu_out = 32'h0000_1234;
    rd_addr = 5'd1;
    reg_wr  = 1'b1;
    tick();
    check("jal_reg_wr", 32'(wb_reg_wr),  1);
    check("jal_rd",     32'(wb_rd_addr), 1);
    check("jal_data",   wb_data,         32'h0000_0044);

    nop();
    alu_out = 32'hCAFE_0001;
    rd_addr = 5'd0;
    reg_wr  = 1'b1;
    dm_ack  = 1'b1;  // stray ack with no request
    #1;
    check("x0_req", 32'(dm_req), 0);
    tick();
    check("x0_reg_wr", 32'(wb_reg_wr), 0);
    check("x0_data",   wb_data,        32'hCAFE_0001);

    nop();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32 pipeline. It consumes the EX/MEM pipeline-register fields and issues loads and stores to the data-memory port through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. It aligns, sign- or zero-extends load data and registers the write-back result into the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of WAIT cycles before the access is abandoned (range 1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- datatype  in  3  access size, funct3 code: 0=B, 1=H, 2=W, 4=BU, 5=HU. Other codes are treated as W.
- alu_out  in  32  effective address for loads and stores, otherwise the ALU result.
- dm_data  in  32  store data from rs2.
- pc2reg  in  32  PC+4, used for JAL/JALR.
- rd_addr  in  5  destination register.
- reg_wr, rd_src, dm2reg, dm_rd, dm_wr  in  1 each  control bits.
  - rd_src=1 selects pc2reg.
  - dm2reg=1 selects load data.
- dm_req  out  1  memory request.
- dm_addr  out  32  {alu_out[31:2],2'b00}.
- dm_we  out  4  byte write enables; all zero for reads.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  access complete. For reads, dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read word.
- mem_stall  out  1  hold the EX/MEM register and everything upstream.
- wb_reg_wr  out  1  MEM/WB register write enable.
- wb_rd_addr  out  5  MEM/WB destination register.
- wb_data  out  32  MEM/WB write-back value.
- mem_misalign  out  1  registered one-cycle pulse for a misaligned access.
- mem_bus_err  out  1  registered one-cycle pulse on timeout.

## Operation
Access and alignment:
- access = dm_rd | dm_wr. If both are set, dm_rd wins and dm_we=0.
- Misaligned: H/HU with alu_out[0]=1, or W with alu_out[1:0]!=0. B is never misaligned.
- A misaligned access issues no dm_req. Its write-back is suppressed and mem_misalign pulses in the next cycle.

Store lanes:
- SB: dm_we=1<<a[1:0], dm_wdata={4{dm_data[7:0]}}.
- SH: dm_we=a[1]?4'b1100:4'b0011, dm_wdata={2{dm_data[15:0]}}.
- SW: dm_we=4'b1111, dm_wdata=dm_data.

Load extraction:
- Select the byte at a[1:0] or the halfword at a[1], where a=alu_out.
- Codes 0 and 1 sign-extend. Codes 4 and 5 zero-extend. W passes the word unchanged.

Result and write-back:
- result = dm2reg ? load_ext : (rd_src ? pc2reg : alu_out).
- The MEM/WB register loads result when the stage completes.
- wb_reg_wr = reg_wr & (rd_addr!=0) & ~misaligned & ~timeout.

FSM states are IDLE and WAIT; an 8-bit wait counter runs in WAIT.
- IDLE, aligned access:
  - dm_req=1, combinational from the inputs.
  - If dm_ack in the same cycle: zero-wait completion, mem_stall=0, MEM/WB loads, stay in IDLE.
  - Otherwise mem_stall=1, counter cleared to 1, next state WAIT.
- IDLE, no access: MEM/WB loads result directly, no stall.
- WAIT:
  - dm_req=1, and dm_addr, dm_we and dm_wdata stay stable (the inputs are held by the stall).
  - On dm_ack: mem_stall=0, MEM/WB loads, next state IDLE.
  - Else, if counter==TIMEOUT: mem_stall=0, MEM/WB loads a bubble, mem_bus_err pulses next cycle, next state IDLE.
  - Else: counter increments and mem_stall=1.
- While mem_stall=1, MEM/WB loads a bubble: wb_reg_wr=0, wb_rd_addr=0, wb_data=0.
- dm_ack in IDLE without a request is ignored.

## Timing
- Reset: state=IDLE, counter=0. dm_req, dm_we, mem_stall, wb_reg_wr, wb_rd_addr, wb_data, mem_misalign and mem_bus_err are all 0.
- dm_addr and dm_wdata are combinational from the inputs.
- Reset during WAIT: the outstanding request is dropped, dm_req goes to 0 in the cycle after the reset edge, and no write-back occurs.
- Latency:
  - Non-memory instruction and zero-wait access: wb_* valid 1 cycle after presentation.
  - Access acked after N wait cycles: wb_* valid N+1 cycles after presentation, with mem_stall high for N cycles.
- mem_stall depends combinationally on dm_ack. The memory must not depend combinationally on mem_stall.
- Timeout: stall lasts exactly TIMEOUT cycles. mem_bus_err is high in the cycle after the release edge.
- Back-to-back accesses: a new access may issue in the cycle immediately after an ack.

## Test plan
- Ack in the same cycle as the request, LW at 0x100 with dm_rdata=0xDEADBEEF, rd=5, dm2reg=1 → next cycle wb_reg_wr=1, wb_rd_addr=5, wb_data=0xDEADBEEF, mem_stall never high.
- LB at 0x103 with dm_rdata=0x80_00_00_00 → wb_data=0xFFFFFF80. Same access as LBU → 0x00000080. LH at 0x102 with rdata=0x8001_0000 → 0xFFFF8001.
- SB at 0x201 with dm_data=0x000000AB and dm_ack held low 3 cycles → dm_we=4'b0010, dm_wdata=0xABABABAB, dm_addr=0x200. mem_stall high 3 cycles, dm_req held steady, wb_reg_wr=0.
- LW at 0x102 → dm_req=0, no stall, mem_misalign=1 for one cycle, wb_reg_wr=0. Follow with SH at 0x101 → same result.
- TIMEOUT=4 with a load never acked → mem_stall high exactly 4 cycles, then mem_bus_err pulses once, wb_reg_wr=0, FSM back in IDLE.
- rst asserted during the 2nd WAIT cycle → next cycle dm_req=0, mem_stall=0, all wb_* outputs 0. JAL with rd_src=1, pc2reg=0x44, rd=1 → wb_data=0x44. Any instruction with rd=0 → wb_reg_wr=0.
